// File: rtl/fc_seq_pkg.sv
// Shared state encoding and per-layer geometry for the three-layer FC sequencer.
package fc_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_W,
        S_KICK,
        S_RUN,
        S_FWD,
        S_DONE
    } state_t;

    localparam int L0_IN     = 100;
    localparam int L0_OUT    = 120;
    localparam int L1_OUT    = 84;
    localparam int L2_OUT    = 10;
    localparam int L0_TILES  = 4;
    localparam int X_BEATS   = L0_IN * L0_TILES;
    localparam int RES_DEPTH = 128;

    // Slice 0 is layer 0; each later layer consumes the previous layer's outputs.
    localparam logic [2:0][8:0] LAYER_IN    = {9'(L1_OUT), 9'(L0_OUT), 9'(L0_IN)};
    localparam logic [2:0][6:0] LAYER_OUT   = {7'(L2_OUT), 7'(L1_OUT), 7'(L0_OUT)};
    localparam logic [2:0][2:0] LAYER_TILES = {3'd1, 3'd1, 3'(L0_TILES)};

    function automatic logic [16:0] w_beats(input logic [1:0] layer);
        int n;
        n = int'(LAYER_IN[layer]) * int'(LAYER_TILES[layer]) * int'(LAYER_OUT[layer]);
        return 17'(n);
    endfunction
endpackage

// File: rtl/fc_result_buf.sv
// Register file holding one layer's output nodes until they are forwarded to the ifmap buffer.
module fc_result_buf
    import fc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr_en,
    input  logic [6:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_data
);
    logic [7:0] r_mem [RES_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fc_layer_sequencer.sv
// Runs the three FC layers back to back on one FC datapath: load ifmap/weights, kick, capture, forward.
module fc_layer_sequencer
    import fc_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        x_valid_i,
    input  logic [7:0]  x_data_i,
    output logic        x_ready_o,
    input  logic        w_valid_i,
    input  logic [7:0]  w_data_i,
    output logic        w_ready_o,
    output logic        fc_start_o,
    output logic [8:0]  fc_in_node_num_o,
    output logic [6:0]  fc_out_node_num_o,
    output logic [1:0]  fc_nth_fully_o,
    output logic        wbuf_wren_o,
    output logic [16:0] wbuf_wrptr_o,
    output logic [7:0]  wbuf_wdata_o,
    output logic        ifmap_wren_o,
    output logic [9:0]  ifmap_wrptr_o,
    output logic [7:0]  ifmap_wdata_o,
    input  logic [7:0]  fc_result_i,
    input  logic        fc_valid_i,
    input  logic        fc_last_i,
    output logic [7:0]  res_data_o,
    output logic        res_valid_o,
    output logic        res_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    state_t      r_state, w_next;
    logic [1:0]  r_layer;
    logic [16:0] r_beat;
    logic [6:0]  r_cnt;
    logic        r_err;
    logic [8:0]  r_in_num;
    logic [6:0]  r_out_num;
    logic [1:0]  r_nth;

    logic [6:0]  w_out;
    logic [16:0] w_w_total;
    logic [7:0]  w_cnt_inc;
    logic        w_x_acc, w_w_acc, w_cap, w_drop, w_fc_end;
    logic [7:0]  w_buf_rdata;

    assign w_out     = LAYER_OUT[r_layer];
    assign w_w_total = w_beats(r_layer);
    assign w_cnt_inc = {1'b0, r_cnt} + 8'd1;
    assign w_x_acc   = (r_state == S_LOAD_X) && x_valid_i;
    assign w_w_acc   = (r_state == S_LOAD_W) && w_valid_i;
    assign w_cap     = (r_state == S_RUN) && fc_valid_i && (r_cnt < w_out);
    assign w_drop    = (r_state == S_RUN) && fc_valid_i && (r_cnt >= w_out);
    assign w_fc_end  = (r_state == S_RUN) && fc_valid_i && fc_last_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_next = S_LOAD_X;
            S_LOAD_X: if (w_x_acc && r_beat == 17'(X_BEATS - 1)) w_next = S_LOAD_W;
            S_LOAD_W: if (w_w_acc && r_beat == w_w_total - 17'd1) w_next = S_KICK;
            S_KICK:   w_next = S_RUN;
            S_RUN:    if (w_fc_end) w_next = (r_layer == 2'd2) ? S_DONE : S_FWD;
            S_FWD:    if (r_cnt == w_out - 7'd1) w_next = S_LOAD_W;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Beat and capture/forward counters restart on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= '0;
            r_cnt     <= '0;
            r_layer   <= '0;
            r_err     <= 1'b0;
            r_in_num  <= '0;
            r_out_num <= '0;
            r_nth     <= '0;
        end else begin
            if (r_state != w_next)           r_beat <= '0;
            else if (w_x_acc || w_w_acc)     r_beat <= r_beat + 17'd1;

            if (r_state != w_next)           r_cnt <= '0;
            else if (w_cap || r_state == S_FWD) r_cnt <= r_cnt + 7'd1;

            if (r_state == S_IDLE && start_i) begin
                r_layer <= '0;
                r_err   <= 1'b0;
            end else if (r_state == S_FWD && w_next == S_LOAD_W) begin
                r_layer <= r_layer + 2'd1;
            end

            if (w_drop || (w_fc_end && w_cnt_inc != {1'b0, w_out})) r_err <= 1'b1;

            if (r_state == S_LOAD_W && w_next == S_KICK) begin
                r_in_num  <= LAYER_IN[r_layer];
                r_out_num <= w_out;
                r_nth     <= r_layer;
            end
        end
    end

    fc_result_buf u_result_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_cap),
        .i_wr_addr (r_cnt),
        .i_wr_data (fc_result_i),
        .i_rd_addr (r_cnt),
        .o_rd_data (w_buf_rdata)
    );

    always_comb begin
        x_ready_o     = 1'b0;
        w_ready_o     = 1'b0;
        ifmap_wren_o  = 1'b0;
        ifmap_wrptr_o = '0;
        ifmap_wdata_o = '0;
        wbuf_wren_o   = 1'b0;
        wbuf_wrptr_o  = '0;
        wbuf_wdata_o  = '0;
        case (r_state)
            S_LOAD_X: begin
                x_ready_o     = 1'b1;
                ifmap_wren_o  = x_valid_i;
                ifmap_wrptr_o = r_beat[9:0];
                ifmap_wdata_o = x_valid_i ? x_data_i : 8'd0;
            end
            S_LOAD_W: begin
                w_ready_o    = 1'b1;
                wbuf_wren_o  = w_valid_i;
                wbuf_wrptr_o = r_beat;
                wbuf_wdata_o = w_valid_i ? w_data_i : 8'd0;
            end
            S_FWD: begin
                ifmap_wren_o  = 1'b1;
                ifmap_wrptr_o = {3'd0, r_cnt};
                ifmap_wdata_o = w_buf_rdata;
            end
            default: ;
        endcase
    end

    // Final-layer beats bypass the buffer so the consumer sees them in the capture cycle.
    assign res_valid_o       = w_cap && (r_layer == 2'd2);
    assign res_data_o        = res_valid_o ? fc_result_i : 8'd0;
    assign res_last_o        = res_valid_o && fc_last_i;
    assign fc_start_o        = (r_state == S_KICK);
    assign fc_in_node_num_o  = r_in_num;
    assign fc_out_node_num_o = r_out_num;
    assign fc_nth_fully_o    = r_nth;
    assign busy_o            = (r_state != S_IDLE);
    assign done_o            = (r_state == S_DONE);
    assign err_o             = r_err;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: stream drivers, an FC output model and write monitors.
module tb_fc_layer_sequencer;
  localparam int X_N     = 400;
  localparam int W_TOTAL = 48000 + 10080 + 840;
  localparam int EXP_IN  [3] = '{100, 120, 84};
  localparam int EXP_OUT [3] = '{120, 84, 10};
  localparam int EXP_WB  [3] = '{48000, 10080, 840};
  localparam int MODEL_N [3] = '{120, 83, 10};

  logic        clk, rst_n, start_i;
  logic        x_valid_i, x_ready_o, w_valid_i, w_ready_o;
  logic [7:0]  x_data_i, w_data_i;
  logic        fc_start_o;
  logic [8:0]  fc_in_node_num_o;
  logic [6:0]  fc_out_node_num_o;
  logic [1:0]  fc_nth_fully_o;
  logic        wbuf_wren_o, ifmap_wren_o;
  logic [16:0] wbuf_wrptr_o;
  logic [7:0]  wbuf_wdata_o, ifmap_wdata_o;
  logic [9:0]  ifmap_wrptr_o;
  logic [7:0]  fc_result_i, res_data_o;
  logic        fc_valid_i, fc_last_i, res_valid_o, res_last_o;
  logic        busy_o, done_o, err_o;

  fc_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .x_valid_i(x_valid_i), .x_data_i(x_data_i), .x_ready_o(x_ready_o),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .fc_start_o(fc_start_o), .fc_in_node_num_o(fc_in_node_num_o),
    .fc_out_node_num_o(fc_out_node_num_o), .fc_nth_fully_o(fc_nth_fully_o),
    .wbuf_wren_o(wbuf_wren_o), .wbuf_wrptr_o(wbuf_wrptr_o), .wbuf_wdata_o(wbuf_wdata_o),
    .ifmap_wren_o(ifmap_wren_o), .ifmap_wrptr_o(ifmap_wrptr_o), .ifmap_wdata_o(ifmap_wdata_o),
    .fc_result_i(fc_result_i), .fc_valid_i(fc_valid_i), .fc_last_i(fc_last_i),
    .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [17:0] x_exp_q[$];
  logic [24:0] w_exp_q[$];
  logic [17:0] fwd_exp_q[$];
  logic [8:0]  res_exp_q[$];
  logic [7:0]  model_buf [128];
  int n_checks = 0;
  int n_fail   = 0;
  int kick_cnt = 0;
  int done_cnt = 0;
  int res_cnt  = 0;
  int xcount   = 0;
  int wcount   = 0;
  bit main_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {22'd0, busy_o, x_ready_o, w_ready_o, fc_start_o, ifmap_wren_o,
                           wbuf_wren_o, res_valid_o, res_last_o, done_o, err_o}, 32'd0);
    check({tag, "_nums"}, {14'd0, fc_in_node_num_o, fc_out_node_num_o, fc_nth_fully_o}, 32'd0);
    check({tag, "_ptrs"}, {5'd0, wbuf_wrptr_o, ifmap_wrptr_o}, 32'd0);
    check({tag, "_data"}, {8'd0, wbuf_wdata_o, ifmap_wdata_o, res_data_o}, 32'd0);
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic drive_x(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 3000) begin
      @(posedge clk); #1;
      if (x_ready_o) begin
        x_valid_i = 1'b1;
        x_data_i  = 8'(sent * 7 + 3);
        x_exp_q.push_back({10'(sent), x_data_i});
        sent++;
        guard = 0;
      end else begin
        x_valid_i = 1'b0;
        guard++;
      end
    end
    check("x_driver_beats", sent, n);
    @(posedge clk); #1 x_valid_i = 1'b0;
  endtask

  task automatic drive_w(input int n, input bit stall);
    int sent = 0;
    int lyr = 0;
    int ptr = 0;
    int guard = 0;
    logic [7:0] d;
    while (sent < n && guard < 3000) begin
      @(posedge clk); #1;
      if (!w_ready_o) begin
        w_valid_i = 1'b1;
        w_data_i  = 8'hEE;
        guard++;
      end else if (stall && lyr > 0 && $urandom_range(0, 99) < 30) begin
        w_valid_i = 1'b0;
      end else begin
        d = 8'(sent * 13 + (sent >> 8));
        w_valid_i = 1'b1;
        w_data_i  = d;
        w_exp_q.push_back({17'(ptr), d});
        sent++;
        ptr++;
        guard = 0;
        if (ptr == EXP_WB[lyr]) begin
          ptr = 0;
          lyr++;
        end
      end
    end
    check("w_driver_beats", sent, n);
    @(posedge clk); #1 w_valid_i = 1'b0;
  endtask

  // FC output model: after each kick emits MODEL_N beats with random gaps
  initial begin : fc_model
    int lyr;
    int idx;
    int m_kick = 0;
    fc_valid_i  = 1'b0;
    fc_last_i   = 1'b0;
    fc_result_i = 8'd0;
    for (int i = 0; i < 128; i++) model_buf[i] = 8'd0;
    forever begin
      @(negedge clk);
      if (fc_start_o && m_kick < 3) begin
        lyr = m_kick;
        m_kick++;
        idx = 0;
        while (idx < MODEL_N[lyr]) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 99) < 20) begin
            fc_valid_i = 1'b0;
            fc_last_i  = 1'b0;
          end else begin
            fc_valid_i  = 1'b1;
            fc_result_i = 8'(lyr * 50 + idx * 3 + 1);
            fc_last_i   = (idx == MODEL_N[lyr] - 1);
            if (idx < EXP_OUT[lyr]) model_buf[idx] = fc_result_i;
            if (lyr == 2) res_exp_q.push_back({fc_last_i, fc_result_i});
            if (fc_last_i && lyr < 2)
              for (int k = 0; k < EXP_OUT[lyr]; k++) fwd_exp_q.push_back({10'(k), model_buf[k]});
            idx++;
          end
        end
        @(posedge clk); #1;
        fc_valid_i = 1'b0;
        fc_last_i  = 1'b0;
      end
    end
  end

  // monitor: pops expectations as the DUT writes
  initial begin : monitor
    logic prev_start = 1'b0;
    logic [17:0] ex18;
    logic [24:0] ex25;
    logic [8:0]  ex9;
    forever begin
      @(negedge clk);
      if (ifmap_wren_o && x_ready_o) begin
        xcount++;
        check("x_q_nonempty", x_exp_q.size() != 0, 1);
        if (x_exp_q.size() != 0) begin
          ex18 = x_exp_q.pop_front();
          check("ifmap_load_x", {ifmap_wrptr_o, ifmap_wdata_o}, ex18);
        end
      end else if (ifmap_wren_o) begin
        check("fwd_q_nonempty", fwd_exp_q.size() != 0, 1);
        if (fwd_exp_q.size() != 0) begin
          ex18 = fwd_exp_q.pop_front();
          check("ifmap_fwd", {ifmap_wrptr_o, ifmap_wdata_o}, ex18);
        end
      end
      if (wbuf_wren_o) begin
        wcount++;
        check("w_q_nonempty", w_exp_q.size() != 0, 1);
        if (w_exp_q.size() != 0) begin
          ex25 = w_exp_q.pop_front();
          check("wbuf_write", {wbuf_wrptr_o, wbuf_wdata_o}, ex25);
        end
      end
      if (fc_start_o) begin
        check("kick_pulse_width", prev_start, 0);
        check("kick_in_range", kick_cnt < 3, 1);
        if (kick_cnt < 3) begin
          check("kick_nth", fc_nth_fully_o, kick_cnt);
          check("kick_in_num", fc_in_node_num_o, EXP_IN[kick_cnt]);
          check("kick_out_num", fc_out_node_num_o, EXP_OUT[kick_cnt]);
          check("kick_w_beats", wcount, EXP_WB[kick_cnt]);
          if (kick_cnt == 0) check("kick_x_beats", xcount, X_N);
        end
        wcount = 0;
        kick_cnt++;
      end
      prev_start = fc_start_o;
      if (res_valid_o) begin
        res_cnt++;
        check("res_q_nonempty", res_exp_q.size() != 0, 1);
        if (res_exp_q.size() != 0) begin
          ex9 = res_exp_q.pop_front();
          check("res_beat", {res_last_o, res_data_o}, ex9);
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_while_busy", busy_o, 1);
      end
    end
  end

  task automatic check_queues_empty(input string tag);
    check({tag, "_xq"}, x_exp_q.size(), 0);
    check({tag, "_wq"}, w_exp_q.size(), 0);
    check({tag, "_fwdq"}, fwd_exp_q.size(), 0);
    check({tag, "_resq"}, res_exp_q.size(), 0);
  endtask

  initial begin : main
    int g;
    rst_n = 1'b0; start_i = 1'b0;
    x_valid_i = 1'b0; x_data_i = 8'd0;
    w_valid_i = 1'b0; w_data_i = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset");

    // Run A: full run, stalled weights in layers 1/2, short layer 1, start pulsed during RUN
    pulse_start();
    fork
      drive_x(X_N);
      drive_w(W_TOTAL, 1'b1);
      begin
        g = 0;
        while (kick_cnt == 0 && g < 60000) begin @(negedge clk); g++; end
        check("kick0_seen", kick_cnt > 0, 1);
        repeat (3) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check("start_in_run_busy", busy_o, 1);
        check("start_in_run_xready", x_ready_o, 0);
        check("start_in_run_nth", fc_nth_fully_o, 0);
      end
    join
    g = 0;
    while (done_cnt == 0 && g < 5000) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    check("runA_done_count", done_cnt, 1);
    check("runA_kicks", kick_cnt, 3);
    check("runA_res_beats", res_cnt, 10);
    check("runA_err_sticky", err_o, 1);
    check("runA_idle", busy_o, 0);
    check_queues_empty("runA");

    // Run B: start clears err, then async reset in the middle of LOAD_W
    pulse_start();
    @(negedge clk);
    check("runB_err_cleared", err_o, 0);
    check("runB_busy", busy_o, 1);
    fork
      drive_x(X_N);
      drive_w(50, 1'b0);
    join
    repeat (3) @(negedge clk);
    check("runB_in_load_w", w_ready_o, 1);
    check("runB_ptr_holds", wbuf_wrptr_o, 50);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_quiet("midrun_reset");
    check_queues_empty("runB");
    @(posedge clk); #1 rst_n = 1'b1;

    // Run C: fresh start after reset loads from pointer 0 again
    pulse_start();
    fork
      drive_x(X_N);
      drive_w(20, 1'b0);
    join
    repeat (3) @(negedge clk);
    check("runC_in_load_w", w_ready_o, 1);
    check("runC_ptr", wbuf_wrptr_o, 20);
    check("runC_no_kick", kick_cnt, 3);
    check_queues_empty("runC");

    main_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    check("watchdog_main_done", main_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
Controller that runs the three fully-connected layers back to back on the single FC datapath (FC_TOP).
For each layer it fills the ifmap and weight buffers, pulses start, and captures the output nodes.
Layer 0 takes its ifmap from an external stream; layers 1 and 2 take the captured outputs of the previous layer.
It sits between the conv/pool output stream plus the weight DMA stream and FC_TOP, and streams out the final-layer results.

Parameters:
L0_IN, 100, input nodes per tile, layer 0 (4 tiles, 400 ifmap bytes)
L0_OUT, 120, output nodes, layer 0
L1_OUT, 84, output nodes, layer 1 (input count = L0_OUT)
L2_OUT, 10, output nodes, layer 2 (input count = L1_OUT)
L0_TILES, 4, tile count, layer 0 (layers 1 and 2 use 1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start_i  in  1  begin a 3-layer run; ignored while busy_o=1
x_valid_i / x_data_i / x_ready_o  in/in/out  1/8/1  layer-0 ifmap stream
w_valid_i / w_data_i / w_ready_o  in/in/out  1/8/1  weight stream, all layers in order
fc_start_o  out  1  one-cycle start pulse to FC
fc_in_node_num_o  out  9  per-layer input node count
fc_out_node_num_o  out  7  per-layer output node count
fc_nth_fully_o  out  2  layer index 0..2
wbuf_wren_o / wbuf_wrptr_o / wbuf_wdata_o  out  1/17/8  weight buffer write
ifmap_wren_o / ifmap_wrptr_o / ifmap_wdata_o  out  1/10/8  ifmap buffer write
fc_result_i / fc_valid_i / fc_last_i  in  8/1/1  FC output nodes
res_data_o / res_valid_o / res_last_o  out  8/1/1  final-layer results
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at end of run
err_o  out  1  sticky count-mismatch flag; cleared on start_i

Behaviour:
- Reset: state IDLE; all outputs 0; layer counter 0.
- States: IDLE, LOAD_X, LOAD_W, KICK, RUN, FWD, DONE.
- IDLE + start_i: clear err_o, set layer=0, go to LOAD_X.
- LOAD_X:
  - x_ready_o=1.
  - Each accepted beat drives ifmap_wren_o=1 in the same cycle, with wrptr = beat count and wdata = x_data_i.
  - After L0_IN*L0_TILES beats, go to LOAD_W.
- LOAD_W:
  - w_ready_o=1; each accepted beat is written to the weight buffer at wrptr 0,1,2,...
  - Beat count per layer is IN*TILES*OUT: 48000, 10080, 840.
  - On the last beat, go to KICK.
  - The stream may stall any cycle; pointers hold while it stalls.
- KICK:
  - fc_start_o=1 for exactly 1 cycle.
  - fc_in_node_num_o, fc_out_node_num_o and fc_nth_fully_o are valid this cycle and held stable until the next KICK.
  - fc_in_node_num_o is the per-tile count (L0_IN for layer 0). Then go to RUN.
- RUN:
  - Each cycle with fc_valid_i=1 writes fc_result_i into the internal result buffer (128x8 registers) at the capture count.
  - In layer 2, the same beat is also driven combinationally to res_data_o/res_valid_o, with res_last_o=fc_last_i.
  - On fc_last_i: if capture count+1 != OUT, set err_o.
  - Layer 2 then goes to DONE; other layers go to FWD.
  - A fc_valid_i beat arriving after the count reaches OUT without fc_last_i sets err_o and is dropped.
- FWD:
  - Copies result buffer entries 0..OUT-1 into the ifmap buffer at wrptr 0..OUT-1, one entry per cycle, with no stall.
  - Then layer++ and go to LOAD_W.
- DONE: done_o=1 for 1 cycle; return to IDLE.
- busy_o = (state != IDLE).
- There is no back-pressure on FC outputs: res_* has no ready, and the consumer must always accept.
- start_i while busy is ignored. x_valid_i outside LOAD_X is ignored (x_ready_o=0). Likewise for w_valid_i outside LOAD_W.
- Async reset mid-run: return to IDLE immediately with all counters cleared. FC_TOP is reset by the same rst_n.
- Counters: beat counter 17 bits, capture/forward counter 7 bits; no wrap within legal parameters.

Decomposition:
- Package fc_seq_pkg holds:
  - the state enum;
  - per-layer constant arrays (IN, OUT, TILES) indexed by layer;
  - a function returning weight beat count per layer.
- One sub-module, fc_result_buf: 128x8 register file with 1 write port and 1 combinational read port, used by RUN and FWD.

Test Plan:
- Full run with incrementing x/w data and an FC model → exactly 400 ifmap writes, then 48000/10080/840 weight writes per layer, 3 fc_start_o pulses with nth_fully 0,1,2, 10 res_valid_o beats with res_last_o on the 10th, one done_o.
- Randomly stalled w_valid_i (30% idle) → wbuf_wrptr_o contiguous with no gaps or duplicates; final result identical to the unstalled run.
- FWD check: layer-0 results 0..119 → ifmap writes at wrptr 0..119 with the same data before layer-1 LOAD_W.
- Model emits fc_last_i after 83 beats in layer 1 → err_o=1, run still completes; next start_i clears err_o.
- start_i pulsed during RUN → ignored: no restart and layer counter unchanged.
- rst_n asserted mid LOAD_W → all outputs 0 and state IDLE; a fresh start_i completes a normal run.
